// File: rtl/parameter_pkg.sv
// Shared sizing constants for the rename-stage physical register free list.
//   ARCH_REGS : architectural registers, mapped to p0..p(ARCH_REGS-1) at reset
//   PHY_REGS  : total physical registers
//   PHY_WIDTH : width of a physical register ID
//   DEPTH     : free-list entries (PHY_REGS - ARCH_REGS), power of two
//   IDX_WIDTH : width of a free-list pointer
//   CNT_WIDTH : width of the free-entry counter (holds 0..DEPTH)
package parameter_pkg;

  localparam int ARCH_REGS = 32;
  localparam int PHY_REGS  = 64;
  localparam int PHY_WIDTH = 6;
  localparam int DEPTH     = PHY_REGS - ARCH_REGS;
  localparam int IDX_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = IDX_WIDTH + 1;

endpackage

// File: rtl/popcount2.sv
// Two-bit population count, shared by the allocation and release paths.
//   in_i    : two request/valid bits
//   count_o : number of bits set (0..2)
module popcount2 (
  input  logic [1:0] in_i,
  output logic [1:0] count_o
);

  assign count_o = {1'b0, in_i[0]} + {1'b0, in_i[1]};

endmodule

// File: rtl/free_list.sv
// Physical register free list for a 2-wide rename stage. A circular FIFO of
// free physical register IDs: rename pops from head, ROB commit pushes
// released registers at tail. A separate committed head lets a flush restore
// the speculative head in one cycle.
//   clk, rst             : clock, synchronous active-high reset
//   free_list_valid      : allocation request per rename slot
//   rd_phy_new_0/1       : registers granted to slots 0/1 (combinational)
//   alloc_ready          : at least two entries free
//   commit_valid         : release per commit slot
//   commit_phy_old_0/1   : registers released by commit slots 0/1
//   flush                : squash all speculative allocations
//   free_count           : number of free entries
//   overflow_err         : sticky, a release arrived while the list was full
module free_list #(
  parameter int ARCH_REGS = parameter_pkg::ARCH_REGS,
  parameter int PHY_REGS  = parameter_pkg::PHY_REGS,
  parameter int PHY_WIDTH = parameter_pkg::PHY_WIDTH,
  parameter int DEPTH     = PHY_REGS - ARCH_REGS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 free_list_valid,
  output logic [PHY_WIDTH-1:0]       rd_phy_new_0,
  output logic [PHY_WIDTH-1:0]       rd_phy_new_1,
  output logic                       alloc_ready,
  input  logic [1:0]                 commit_valid,
  input  logic [PHY_WIDTH-1:0]       commit_phy_old_0,
  input  logic [PHY_WIDTH-1:0]       commit_phy_old_1,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     free_count,
  output logic                       overflow_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PHY_WIDTH-1:0] fifo_q [DEPTH];
  logic [PHY_WIDTH-1:0] fifo_d [DEPTH];
  logic [IDX_W-1:0]     head_q, head_d;
  logic [IDX_W-1:0]     commit_head_q, commit_head_d;
  logic [IDX_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;

  logic [1:0]           alloc_req;
  logic [1:0]           alloc;
  logic [1:0]           rel;
  logic                 acc0, acc1;
  logic                 dropped;
  logic [IDX_W-1:0]     wr_idx_1;

  popcount2 u_pop_alloc (
    .in_i    (free_list_valid),
    .count_o (alloc_req)
  );

  // Releases are accepted only while the list has room; slot 1 also has to
  // account for slot 0 having just taken a free spot.
  assign acc0 = commit_valid[0] && (count_q < FULL);
  assign acc1 = commit_valid[1] && ((count_q + CNT_W'(acc0)) < FULL);
  assign dropped = (commit_valid[0] && !acc0) || (commit_valid[1] && !acc1);

  popcount2 u_pop_rel (
    .in_i    ({acc1, acc0}),
    .count_o (rel)
  );

  assign alloc_ready  = (count_q >= CNT_W'(2));
  assign free_count   = count_q;
  assign overflow_err = overflow_q;

  // Slot 1 only takes the next entry when slot 0 is also allocating.
  assign rd_phy_new_0 = fifo_q[head_q];
  assign rd_phy_new_1 = fifo_q[head_q + IDX_W'(free_list_valid[0])];

  // Requests are ignored while stalled, and a flush cycle never allocates.
  assign alloc    = (alloc_ready && !flush) ? alloc_req : 2'd0;
  assign wr_idx_1 = tail_q + IDX_W'(acc0);

  // Next-state: releases push at tail in slot order, allocations pop at head.
  // A flush rewinds head to the committed head (including this cycle's
  // commits) and restores the full count, since the committed state always
  // holds exactly DEPTH free registers.
  always_comb begin
    fifo_d        = fifo_q;
    head_d        = head_q + IDX_W'(alloc);
    commit_head_d = commit_head_q + IDX_W'(rel);
    tail_d        = tail_q + IDX_W'(rel);
    count_d       = count_q + CNT_W'(rel) - CNT_W'(alloc);
    overflow_d    = overflow_q | dropped;
    if (acc0) begin
      fifo_d[tail_q] = commit_phy_old_0;
    end
    if (acc1) begin
      fifo_d[wr_idx_1] = commit_phy_old_1;
    end
    if (flush) begin
      head_d  = commit_head_q + IDX_W'(rel);
      count_d = FULL;
    end
  end

  // State registers; reset reloads the list with the registers just above
  // the architectural mappings.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= PHY_WIDTH'(ARCH_REGS + i);
      end
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= '0;
      count_q       <= FULL;
      overflow_q    <= 1'b0;
    end else begin
      fifo_q        <= fifo_d;
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for the rename free list: reset state, single
// and dual allocation, drain to stall and refill, flush recovery with and
// without same-cycle commits, wrap-around of released entries, and overflow.
module tb_free_list;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] freeListValid;
  logic [1:0] commitValid;
  logic [5:0] commitPhyOld0;
  logic [5:0] commitPhyOld1;
  logic       flush;
  logic [5:0] rdPhyNew0;
  logic [5:0] rdPhyNew1;
  logic       allocReady;
  logic [5:0] freeCount;
  logic       overflowErr;

  int checks = 0;
  int errors = 0;

  free_list dut (
    .clk              (clock),
    .rst              (reset),
    .free_list_valid  (freeListValid),
    .rd_phy_new_0     (rdPhyNew0),
    .rd_phy_new_1     (rdPhyNew1),
    .alloc_ready      (allocReady),
    .commit_valid     (commitValid),
    .commit_phy_old_0 (commitPhyOld0),
    .commit_phy_old_1 (commitPhyOld1),
    .flush            (flush),
    .free_count       (freeCount),
    .overflow_err     (overflowErr)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] com,
                               input logic [5:0] old0, input logic [5:0] old1,
                               input logic fl);
    freeListValid = req;
    commitValid   = com;
    commitPhyOld0 = old0;
    commitPhyOld1 = old1;
    flush         = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  // Linear directed sequence; expected values are worked out by hand.
  initial begin
    $display("[TB] start");

    // Reset state and single allocations: 32, 33, 34.
    doReset();
    checkOutput("rst_rd0", rdPhyNew0, 32);
    checkOutput("rst_rd1", rdPhyNew1, 32);
    checkOutput("rst_ready", allocReady, 1);
    checkOutput("rst_count", freeCount, 32);
    checkOutput("rst_ovf", overflowErr, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
      checkOutput("single_rd0", rdPhyNew0, 32 + i);
      tick();
      checkOutput("single_count", freeCount, 31 - i);
    end

    // Dual allocation, then slot 1 alone takes the head entry.
    doReset();
    applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    checkOutput("dual_rd0", rdPhyNew0, 32);
    checkOutput("dual_rd1", rdPhyNew1, 33);
    tick();
    checkOutput("dual_count", freeCount, 30);
    applyStimulus(2'b10, 2'b00, 6'd0, 6'd0, 1'b0);
    checkOutput("slot1only_rd1", rdPhyNew1, 34);
    tick();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    checkOutput("slot1only_head", rdPhyNew0, 35);
    checkOutput("slot1only_count", freeCount, 29);

    // Drain to stall, then refill with 5 and 7 at the wrapped head.
    doReset();
    applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    repeat (16) tick();
    checkOutput("drain_count", freeCount, 0);
    checkOutput("drain_ready", allocReady, 0);
    checkOutput("drain_rd0", rdPhyNew0, 32);
    tick();
    checkOutput("stall_rd0", rdPhyNew0, 32);
    checkOutput("stall_count", freeCount, 0);
    applyStimulus(2'b11, 2'b11, 6'd5, 6'd7, 1'b0);
    tick();
    applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    checkOutput("refill_count", freeCount, 2);
    checkOutput("refill_ready", allocReady, 1);
    checkOutput("refill_rd0", rdPhyNew0, 5);
    checkOutput("refill_rd1", rdPhyNew1, 7);
    tick();
    checkOutput("refill_drain_count", freeCount, 0);

    // Reset overrides allocation, release and flush in the same cycle.
    reset = 1'b1;
    applyStimulus(2'b11, 2'b11, 6'd1, 6'd2, 1'b1);
    tick();
    reset = 1'b0;
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    checkOutput("midrst_rd0", rdPhyNew0, 32);
    checkOutput("midrst_count", freeCount, 32);
    checkOutput("midrst_ovf", overflowErr, 0);

    // Flush recovery: allocate 6, commit two (releasing 3 and 4), flush.
    applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    repeat (3) tick();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    checkOutput("spec_count", freeCount, 26);
    checkOutput("spec_rd0", rdPhyNew0, 38);
    applyStimulus(2'b00, 2'b11, 6'd3, 6'd4, 1'b0);
    tick();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    checkOutput("commit_count", freeCount, 28);
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 1'b1);
    tick();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    checkOutput("flush_count", freeCount, 32);
    checkOutput("flush_rd0", rdPhyNew0, 34);

    // Flush with a same-cycle commit of 9; allocation request is suppressed.
    applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    checkOutput("preflush_rd1", rdPhyNew1, 35);
    tick();
    checkOutput("preflush_count", freeCount, 30);
    applyStimulus(2'b11, 2'b01, 6'd9, 6'd0, 1'b1);
    tick();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    checkOutput("flushcom_count", freeCount, 32);
    checkOutput("flushcom_rd0", rdPhyNew0, 35);
    checkOutput("flushcom_ovf", overflowErr, 0);

    // Allocate 30 to wrap head onto the released entries 4 and 9.
    applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    repeat (15) tick();
    checkOutput("wrap_count", freeCount, 2);
    checkOutput("wrap_rd0", rdPhyNew0, 4);
    checkOutput("wrap_rd1", rdPhyNew1, 9);

    // Overflow: a release while full is dropped and the error is sticky.
    doReset();
    applyStimulus(2'b00, 2'b01, 6'd9, 6'd0, 1'b0);
    tick();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    checkOutput("ovf_set", overflowErr, 1);
    checkOutput("ovf_count", freeCount, 32);
    checkOutput("ovf_rd0", rdPhyNew0, 32);
    tick();
    checkOutput("ovf_sticky", overflowErr, 1);
    applyStimulus(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    checkOutput("ovf_sticky_alloc", overflowErr, 1);
    checkOutput("ovf_alloc_count", freeCount, 31);
    doReset();
    checkOutput("ovf_cleared", overflowErr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the 2-wide rename stage. It is the responder to the rename stage's allocation requests (`free_list_valid`, `rd_phy_new_0/1`) and the sink for registers released at ROB commit (`rd_phy_old`). It is a circular FIFO of physical register IDs with a separate committed head pointer, so it can be restored in one cycle on a pipeline flush.

## Interface
Parameters:
- `ARCH_REGS`, 32: architectural registers; p0..p(ARCH_REGS-1) are the initial architectural mappings.
- `PHY_REGS`, 64: physical registers.
- `PHY_WIDTH`, 6: width of a physical register ID.
- `DEPTH`, PHY_REGS-ARCH_REGS = 32: FIFO entries. Must be a power of two.

Ports:
- `clk`  in  1: clock. The block uses one clock.
- `rst`  in  1: reset, synchronous and active-high.
- `free_list_valid`  in  2: allocation request per rename slot.
- `rd_phy_new_0`  out  PHY_WIDTH: register granted to slot 0.
- `rd_phy_new_1`  out  PHY_WIDTH: register granted to slot 1.
- `alloc_ready`  out  1: at least 2 entries are free. Rename stalls while this is low.
- `commit_valid`  in  2: ROB commit per slot. Asserted only for instructions that allocated a register.
- `commit_phy_old_0`  in  PHY_WIDTH: register released by commit slot 0.
- `commit_phy_old_1`  in  PHY_WIDTH: register released by commit slot 1.
- `flush`  in  1: squash all speculative allocations.
- `free_count`  out  $clog2(DEPTH)+1: number of free entries.
- `overflow_err`  out  1: sticky; a release arrived while the FIFO was full.

## Operation
- **Storage.** `fifo[DEPTH]` of PHY_WIDTH entries, plus `head`, `commit_head` and `tail` pointers, each log2(DEPTH) bits and wrapping modulo DEPTH. `count` is held as a separate register.
- **Reset.** `fifo[i] = ARCH_REGS+i`; `head = commit_head = tail = 0`; `count = DEPTH`; `overflow_err = 0`.
- **Read (combinational).**
  - `rd_phy_new_0 = fifo[head]`.
  - `rd_phy_new_1 = fifo[head + free_list_valid[0]]`, so slot 1 takes the next entry only when slot 0 also allocates.
- **Grant.** `alloc = alloc_ready ? popcount(free_list_valid) : 0`. When `alloc_ready` is low, requests are ignored: no pop, and the outputs carry no meaning.
- **Release.** Each `commit_valid[k]` writes `commit_phy_old_k` at `tail`, in order slot 0 then slot 1, and advances `tail`. Each release also advances `commit_head` by one. Net `rel = popcount(commit_valid)`.
- **Normal update.** `head += alloc`; `count += rel - alloc`.
- **Flush.**
  - `head <= commit_head + rel`, which includes same-cycle commits.
  - `count <= DEPTH`, because the committed state always holds exactly DEPTH free registers.
  - Allocation is suppressed in the flush cycle. Releases in the flush cycle still write and advance `tail`.
- **Overflow.** A release while `count == DEPTH` (before flush correction) is illegal. It is dropped, and `overflow_err` sets and stays set until `rst`.
- **Simultaneous alloc and release at `count == 1`.** `alloc_ready = 0`, so there is no alloc; the release is accepted.
- **Wrap.** All pointer arithmetic is modulo DEPTH. `count` never wraps.

## Timing
- Allocation outputs are combinational from `head`/`fifo`, so rename consumes them in the same cycle it asserts `free_list_valid`.
- Pointer, count and fifo updates take effect at the next `posedge clk`.
- A register released at edge N can be allocated from edge N+1, once `head` reaches it.
- `alloc_ready` and `free_count` are registered-state derived. They reflect updates one cycle after the event.
- Reset values:
  - `rd_phy_new_0 = ARCH_REGS`, `rd_phy_new_1 = ARCH_REGS`.
  - `alloc_ready = 1`, `free_count = DEPTH`, `overflow_err = 0`.
- `rst` asserted mid-operation overrides flush, alloc and release in that cycle.

## Structure
- `parameter_pkg` holds ARCH_REGS, PHY_REGS, PHY_WIDTH and the derived DEPTH and index width.
- No new typedefs are needed.
- Natural sub-module: `popcount2`, a 2-bit population count shared by the alloc and release paths. Everything else is inline.

## Test plan
- **Reset then single allocs.** After reset, request `2'b01` each cycle → grants 32, 33, 34…; `free_count` drops by 1 per cycle.
- **Dual alloc and slot-0-invalid case.** Request `2'b11` → grants 32/33. Then request `2'b10` → `rd_phy_new_1 = 34`, head advances by 1.
- **Drain to stall.** Keep requesting `2'b11` → after 16 cycles `free_count = 0`, `alloc_ready = 0`, head is unchanged while stalled. Release 5 and 7 → `count = 2`, `alloc_ready = 1`, next grants are 5 and 7 after wrap.
- **Flush recovery.** Alloc 6 registers, commit 2 of them (releasing 3 and 4), then flush → `head = commit_head = 2`, `count = 32`, next grant is `fifo[2] = 34`.
- **Flush with same-cycle commit.** Flush asserted with `commit_valid = 2'b01` → `head = commit_head + 1`, `count = 32`, tail entry written.
- **Overflow.** At reset state (full), assert `commit_valid = 2'b01` → entry dropped, `overflow_err = 1` and sticky, `count` stays 32.
